muldiv_unit: RTL

Iterative 32-bit unsigned multiply/divide unit for the single-cycle processor datapath. It sits directly upstream of the writeback result select: its `result` is one candidate input of the 32-bit 2:1 select whose output goes to the register file. A `start`/`busy`/`done` handshake lets the control unit stall the core while an operation runs.

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/muldiv_unit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and defaults for the multiply/divide unit
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [1:0] OP_MULU_LO = 2'b00;
    localparam logic [1:0] OP_MULU_HI = 2'b01;
    localparam logic [1:0] OP_DIVU    = 2'b10;
    localparam logic [1:0] OP_REMU    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative unsigned shift-add multiplier / restoring divider
// One XLEN+1-bit adder/subtractor is shared by both paths; result updates only on completion.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_t              state_q, state_d;
    logic                accept;
    logic                step;
    logic                last;

    logic [CNT_W-1:0]    cnt_q;
    logic [1:0]          op_q;
    logic [XLEN-1:0]     opnd_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [2*XLEN-1:0]   acc_d;
    logic [XLEN-1:0]     result_q;
    logic [XLEN-1:0]     res_d;

    logic                is_div;
    logic                alu_sub;
    logic [XLEN:0]       alu_x;
    logic [XLEN:0]       alu_y;
    logic [XLEN:0]       alu_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    accept  = 1'b1;
                end
            end
            S_RUN: begin
                step = 1'b1;
                // the iteration that moves the counter to XLEN is the final one
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    last    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    accept  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

    // acc holds product (hi:lo) for multiply, remainder:quotient for divide
    always_comb begin
        is_div  = op_q[1];
        alu_sub = is_div;
        alu_x   = '0;
        alu_y   = '0;
        if (is_div) begin
            alu_x = acc_q[2*XLEN-1:XLEN-1];
            alu_y = {1'b0, opnd_q};
        end else begin
            alu_x = {1'b0, acc_q[2*XLEN-1:XLEN]};
            alu_y = acc_q[0] ? {1'b0, opnd_q} : '0;
        end
        alu_res = alu_x + (alu_sub ? ~alu_y : alu_y) + {{XLEN{1'b0}}, alu_sub};

        acc_d = acc_q;
        if (!is_div) begin
            acc_d = {alu_res, acc_q[XLEN-1:1]};
        end else if (alu_res[XLEN]) begin
            // borrow out: restore by keeping the shifted remainder, quotient bit 0
            acc_d = {acc_q[2*XLEN-2:0], 1'b0};
        end else begin
            acc_d = {alu_res[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end

        res_d = acc_d[XLEN-1:0];
        case (op_q)
            OP_MULU_LO, OP_DIVU: res_d = acc_d[XLEN-1:0];
            OP_MULU_HI, OP_REMU: res_d = acc_d[2*XLEN-1:XLEN];
            default:             res_d = acc_d[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_MULU_LO;
            cnt_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q   <= op;
            cnt_q  <= '0;
            acc_q  <= {{XLEN{1'b0}}, (op[1] ? a : b)};
            opnd_q <= op[1] ? b : a;
        end else if (step) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last) begin
                result_q <= res_d;
            end
        end
    end

endmodule
